// File: rtl/if_pkg.sv
// if_pkg: shared fetch-stage types for the instruction fetch queue.
package if_pkg;
  localparam int WORD_W = 32;
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;
  localparam fetch_entry_t FETCH_ENTRY_NOP = '0;
endpackage

// File: rtl/fetch_queue_ram.sv
// fetch_queue_ram: unreset entry storage, one sync write port, one async read port.
module fetch_queue_ram import if_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t rdata
);
  fetch_entry_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: show-ahead fetch-to-decode FIFO with flush on taken branch.
// Optional same-cycle empty-queue bypass under FETCH_QUEUE_BYPASS_EN.
module fetch_queue import if_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [WORD_W-1:0]       PC_in,
  input  logic [WORD_W-1:0]       Instruction_in,
  input  logic                    rd_en,
  output logic [WORD_W-1:0]       PC,
  output logic [WORD_W-1:0]       Instruction,
  output logic                    valid,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  fetch_entry_t head;
  logic stored, byp, pop, push;
  assign stored = count != '0;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = !stored && wr_en && !flush;
`else
  assign byp = 1'b0;
`endif
  assign full = count == (AW+1)'(DEPTH);
  assign pop  = rd_en && stored && !flush;
  // a bypassed entry consumed in the same cycle is never stored
  assign push = wr_en && !flush && (!full || pop) && !(byp && rd_en);
  fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({PC_in, Instruction_in}),
    .raddr (rd_ptr),
    .rdata (head)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_comb begin
    valid = stored || byp;
    {PC, Instruction} = byp ? {PC_in, Instruction_in} : stored ? head : FETCH_ENTRY_NOP;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the instruction-fetch stage and the decode stage of the ARM pipeline. It buffers fetched {PC+4, instruction} pairs so fetch keeps running while decode is stalled, drives the fetch-stage freeze when full, and discards all buffered wrong-path entries on a taken branch.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- flush  input  1  taken branch; discard all entries and any same-cycle write
- wr_en  input  1  fetch stage presents a valid entry this cycle
- PC_in  input  32  PC+4 value from fetch
- Instruction_in  input  32  instruction word from fetch
- rd_en  input  1  decode accepts the head entry this cycle
- PC  output  32  head entry PC+4; 0 when not valid
- Instruction  output  32  head entry instruction; 0 when not valid
- valid  output  1  head entry present
- full  output  1  no free entry; wired to the fetch-stage freeze
- count  output  $clog2(DEPTH)+1  occupied entries

## Operation
- Show-ahead FIFO: head entry is visible on PC/Instruction while valid=1; rd_en pops it.
- Write accepted when wr_en=1, flush=0, and (full=0 or pop this cycle).
- Pop occurs when rd_en=1, valid=1, and flush=0. rd_en while empty is ignored.
- Full with wr_en=1 and rd_en=1: pop and push both occur; count unchanged.
- Full with wr_en=1 and rd_en=0: write dropped, no state change. Fetch is frozen by full, so this case only flags an integration error.
- flush=1 overrides everything. Next cycle count=0, valid=0, and pointers reset to 0. Same-cycle wr_en and rd_en are discarded.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count disambiguates full from empty.
- full = (count==DEPTH); valid = (count!=0).

## Timing
- Reset (rst=0, asynchronous): count=0, valid=0, full=0, PC=0, Instruction=0, pointers=0. Storage contents are don't-care.
- Write-to-head latency is 1 cycle: an entry written at edge N is visible after edge N and poppable at edge N+1.
- Outputs are registered or decoded from registered state only. No input-to-output combinational path, except as described under Configuration.
- full rises in the cycle after the write that fills the last entry. It falls in the cycle after the first pop.
- Reset asserted mid-operation clears the queue immediately, regardless of clk.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When count=0 and wr_en=1 and flush=0, valid=1 and PC/Instruction equal PC_in/Instruction_in in the same cycle.
  - If rd_en=1 in that cycle, the entry is consumed and not stored (count stays 0). Otherwise it is stored as normal.
- FETCH_QUEUE_BYPASS_EN undefined: no bypass; the 1-cycle latency applies always.

## Structure
- Shared package if_pkg:
  - WORD_W=32
  - typedef fetch_entry_t {pc[31:0], instr[31:0]}
  - reset constant FETCH_ENTRY_NOP (all zero)
- Sub-module fetch_queue_ram holds the storage:
  - DEPTH×fetch_entry_t register array
  - one synchronous write port
  - one asynchronous read port
  - no reset on the array
- Pointer, count, and flush control live in fetch_queue.

## Test plan
- Reset then idle: rst=0 for 2 cycles, then release -> count=0, valid=0, full=0, PC=0, Instruction=0.
- Fill: write PC_in=4,8,12,16 with Instruction_in=0xE3A01001+i and rd_en=0 -> count=4, full=1. A fifth write of PC_in=20 is dropped, and the head stays PC=4.
- Drain order: after the fill, rd_en=1 for 4 cycles -> PC sequence 4,8,12,16, then valid=0 and count=0.
- Full simultaneous push/pop: full, with wr_en=1 (PC_in=20) and rd_en=1 -> count stays 4. The head becomes PC=8, and PC=20 appears after PC=16.
- Flush: count=3 with flush=1, wr_en=1, PC_in=0x100 -> next cycle count=0, valid=0. The 0x100 entry is never output.
- Wrap and reset mid-run: 10 push/pop cycles cross the pointer wrap with FIFO order preserved. rst=0 pulsed between edges clears count to 0 immediately.
- With FETCH_QUEUE_BYPASS_EN: empty queue, wr_en=1, PC_in=0x40, rd_en=1 -> PC=0x40 and valid=1 in the same cycle, and count stays 0.
